// File: rtl/wb_writeback_pkg.sv
// Shared widths, load funct3 encodings and the ALU result payload for writeback.
package wb_writeback_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned AW         = 5;
  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CNT_W      = 2;
  localparam int unsigned F3_W       = 3;
  localparam int unsigned OFS_W      = 3;
  localparam int unsigned RCNT_W     = 64;

  localparam logic [F3_W-1:0] LB  = 3'd0;
  localparam logic [F3_W-1:0] LH  = 3'd1;
  localparam logic [F3_W-1:0] LW  = 3'd2;
  localparam logic [F3_W-1:0] LD  = 3'd3;
  localparam logic [F3_W-1:0] LBU = 3'd4;
  localparam logic [F3_W-1:0] LHU = 3'd5;
  localparam logic [F3_W-1:0] LWU = 3'd6;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } alu_res_t;

endpackage

// File: rtl/wb_writeback_if.sv
// Producer handshakes and register-file write port of the writeback stage.
interface wb_writeback_if;
  import wb_writeback_pkg::*;

  logic              alu_valid;
  logic              alu_ready;
  logic [AW-1:0]     alu_rd;
  logic [XLEN-1:0]   alu_data;

  logic              lsu_valid;
  logic              lsu_ready;
  logic [AW-1:0]     lsu_rd;
  logic [F3_W-1:0]   lsu_funct3;
  logic [OFS_W-1:0]  lsu_addr_lo;
  logic [XLEN-1:0]   lsu_rdata;

  logic              we;
  logic [AW-1:0]     waddr;
  logic [XLEN-1:0]   wdata;
  logic              retire;
  logic [RCNT_W-1:0] retire_cnt;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_funct3, lsu_addr_lo, lsu_rdata,
    input  alu_ready, lsu_ready,
    input  we, waddr, wdata, retire, retire_cnt
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_funct3, lsu_addr_lo, lsu_rdata,
    output alu_ready, lsu_ready,
    output we, waddr, wdata, retire, retire_cnt
  );
endinterface

// File: rtl/wb_writeback_load_ext.sv
// Extracts the addressed byte/half/word from a load doubleword and extends it.
module wb_writeback_load_ext
  import wb_writeback_pkg::*;
(
  input  logic [F3_W-1:0]  funct3,
  input  logic [OFS_W-1:0] addr_lo,
  input  logic [XLEN-1:0]  rdata,
  output logic [XLEN-1:0]  data_c,
  output logic             ok_c
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] word_v;

  // Lane select; halfword and word offsets drop their misaligned low bits.
  always_comb begin
    byte_v = rdata[{addr_lo, 3'b000} +: 8];
    half_v = rdata[{addr_lo[2:1], 4'b0000} +: 16];
    word_v = rdata[{addr_lo[2], 5'b00000} +: 32];
  end

  // Extension by load type; funct3 7 is not a load and yields no write.
  always_comb begin
    data_c = '0;
    ok_c   = 1'b1;
    case (funct3)
      LB:      data_c = {{(XLEN-8){byte_v[7]}}, byte_v};
      LBU:     data_c = {{(XLEN-8){1'b0}}, byte_v};
      LH:      data_c = {{(XLEN-16){half_v[15]}}, half_v};
      LHU:     data_c = {{(XLEN-16){1'b0}}, half_v};
      LW:      data_c = {{(XLEN-32){word_v[31]}}, word_v};
      LWU:     data_c = {{(XLEN-32){1'b0}}, word_v};
      LD:      data_c = rdata;
      default: ok_c   = 1'b0;
    endcase
  end

endmodule

// File: rtl/wb_writeback.sv
// Writeback stage: buffers ALU results, extends loads, arbitrates and writes the regfile.
module wb_writeback
  import wb_writeback_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  wb_writeback_if.slave bus
);

  alu_res_t          fifo_mem [FIFO_DEPTH];
  logic              wptr;
  logic              rptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;

  logic              alu_push;
  logic              lsu_fire;
  logic              pop;
  logic              sel_valid;
  logic              sel_write;
  logic [AW-1:0]     sel_rd;
  logic [XLEN-1:0]   sel_data;

  logic [XLEN-1:0]   ext_data;
  logic              ext_ok;

  logic              we_q;
  logic [AW-1:0]     waddr_q;
  logic [XLEN-1:0]   wdata_q;
  logic              retire_q;
  logic [RCNT_W-1:0] retire_cnt_q;

  wb_writeback_load_ext u_load_ext (
    .funct3  (bus.lsu_funct3),
    .addr_lo (bus.lsu_addr_lo),
    .rdata   (bus.lsu_rdata),
    .data_c  (ext_data),
    .ok_c    (ext_ok)
  );

  // Readies depend only on occupancy; a full FIFO also stalls the LSU so ALU results drain.
  assign bus.alu_ready = !rst && (count < CNT_W'(FIFO_DEPTH));
  assign bus.lsu_ready = !rst && (count < CNT_W'(FIFO_DEPTH));

  // Arbitration: an accepted load wins, otherwise pop the FIFO head.
  always_comb begin
    alu_push  = bus.alu_valid && bus.alu_ready;
    lsu_fire  = bus.lsu_valid && bus.lsu_ready;
    pop       = !lsu_fire && (count != '0);
    sel_valid = lsu_fire || pop;
    sel_rd    = fifo_mem[rptr].rd;
    sel_data  = fifo_mem[rptr].data;
    sel_write = pop && (fifo_mem[rptr].rd != '0);
    if (lsu_fire) begin
      sel_rd    = bus.lsu_rd;
      sel_data  = ext_data;
      sel_write = ext_ok && (bus.lsu_rd != '0);
    end
    count_nxt = count + CNT_W'(alu_push) - CNT_W'(pop);
  end

  // FIFO storage; contents are don't-care while count is zero.
  always_ff @(posedge clk) begin
    if (alu_push) begin
      fifo_mem[wptr] <= '{rd: bus.alu_rd, data: bus.alu_data};
    end
  end

  // Pointers, occupancy, registered write port and retire accounting.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr         <= 1'b0;
      rptr         <= 1'b0;
      count        <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      retire_q     <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      if (alu_push) wptr <= ~wptr;
      if (pop)      rptr <= ~rptr;
      count    <= count_nxt;
      we_q     <= sel_write;
      retire_q <= sel_valid;
      if (sel_valid) begin
        waddr_q      <= sel_write ? sel_rd : '0;
        wdata_q      <= sel_write ? sel_data : '0;
        retire_cnt_q <= retire_cnt_q + RCNT_W'(1);
      end
    end
  end

  assign bus.we         = we_q;
  assign bus.waddr      = waddr_q;
  assign bus.wdata      = wdata_q;
  assign bus.retire     = retire_q;
  assign bus.retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_wb_writeback.sv
// Directed testbench for wb_writeback with hand-computed expectations.
module tb_wb_writeback;
  import wb_writeback_pkg::*;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  logic [63:0] exp_cnt;

  wb_writeback_if bus ();

  wb_writeback dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid   = 1'b0;
    bus.alu_rd      = '0;
    bus.alu_data    = '0;
    bus.lsu_valid   = 1'b0;
    bus.lsu_rd      = '0;
    bus.lsu_funct3  = '0;
    bus.lsu_addr_lo = '0;
    bus.lsu_rdata   = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    vectors++; if (bus.we !== 1'b0) begin miscompares++; $display("FAIL reset_we got %b expected 0", bus.we); end
    vectors++; if (bus.waddr !== 5'd0) begin miscompares++; $display("FAIL reset_waddr got %0d expected 0", bus.waddr); end
    vectors++; if (bus.wdata !== 64'd0) begin miscompares++; $display("FAIL reset_wdata got %h expected 0", bus.wdata); end
    vectors++; if (bus.retire !== 1'b0) begin miscompares++; $display("FAIL reset_retire got %b expected 0", bus.retire); end
    vectors++; if (bus.retire_cnt !== 64'd0) begin miscompares++; $display("FAIL reset_cnt got %0d expected 0", bus.retire_cnt); end
    vectors++; if (bus.alu_ready !== 1'b0) begin miscompares++; $display("FAIL reset_alu_ready got %b expected 0", bus.alu_ready); end
    vectors++; if (bus.lsu_ready !== 1'b0) begin miscompares++; $display("FAIL reset_lsu_ready got %b expected 0", bus.lsu_ready); end
    rst = 1'b0;
    exp_cnt = 64'd0;
  endtask

  task automatic test_alu();
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd5;
    bus.alu_data  = 64'h1234;
    #1;
    vectors++; if (bus.alu_ready !== 1'b1) begin miscompares++; $display("FAIL alu_ready got %b expected 1", bus.alu_ready); end
    tick();
    bus.alu_valid = 1'b0;
    vectors++; if (bus.we !== 1'b0) begin miscompares++; $display("FAIL alu_lat1_we got %b expected 0", bus.we); end
    tick();
    exp_cnt++;
    vectors++; if (bus.we !== 1'b1) begin miscompares++; $display("FAIL alu_we got %b expected 1", bus.we); end
    vectors++; if (bus.waddr !== 5'd5) begin miscompares++; $display("FAIL alu_waddr got %0d expected 5", bus.waddr); end
    vectors++; if (bus.wdata !== 64'h1234) begin miscompares++; $display("FAIL alu_wdata got %h expected 1234", bus.wdata); end
    vectors++; if (bus.retire !== 1'b1) begin miscompares++; $display("FAIL alu_retire got %b expected 1", bus.retire); end
    vectors++; if (bus.retire_cnt !== 64'd1) begin miscompares++; $display("FAIL alu_cnt got %0d expected 1", bus.retire_cnt); end
    tick();
    vectors++; if (bus.we !== 1'b0 || bus.retire !== 1'b0) begin miscompares++; $display("FAIL alu_idle got we=%b retire=%b expected 0/0", bus.we, bus.retire); end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3;
    logic [2:0]  ofs;
    logic [63:0] rd_v;
    logic [63:0] exp_v;
    for (int i = 0; i < 10; i++) begin
      case (i)
        0: begin f3 = 3'd0; ofs = 3'd1; rd_v = 64'h0000_0000_0000_80FF; exp_v = 64'hFFFF_FFFF_FFFF_FF80; end
        1: begin f3 = 3'd4; ofs = 3'd1; rd_v = 64'h0000_0000_0000_80FF; exp_v = 64'h0000_0000_0000_0080; end
        2: begin f3 = 3'd6; ofs = 3'd4; rd_v = 64'h8765_4321_DEAD_BEEF; exp_v = 64'h0000_0000_8765_4321; end
        3: begin f3 = 3'd2; ofs = 3'd4; rd_v = 64'h8765_4321_DEAD_BEEF; exp_v = 64'hFFFF_FFFF_8765_4321; end
        4: begin f3 = 3'd1; ofs = 3'd3; rd_v = 64'h8765_4321_DEAD_BEEF; exp_v = 64'hFFFF_FFFF_FFFF_DEAD; end
        5: begin f3 = 3'd5; ofs = 3'd6; rd_v = 64'h8765_4321_DEAD_BEEF; exp_v = 64'h0000_0000_0000_8765; end
        6: begin f3 = 3'd2; ofs = 3'd3; rd_v = 64'h8765_4321_DEAD_BEEF; exp_v = 64'hFFFF_FFFF_DEAD_BEEF; end
        7: begin f3 = 3'd3; ofs = 3'd5; rd_v = 64'h8765_4321_DEAD_BEEF; exp_v = 64'h8765_4321_DEAD_BEEF; end
        8: begin f3 = 3'd0; ofs = 3'd7; rd_v = 64'h8765_4321_DEAD_BEEF; exp_v = 64'hFFFF_FFFF_FFFF_FF87; end
        default: begin f3 = 3'd4; ofs = 3'd0; rd_v = 64'h8765_4321_DEAD_BEEF; exp_v = 64'h0000_0000_0000_00EF; end
      endcase
      bus.lsu_valid   = 1'b1;
      bus.lsu_rd      = 5'(i + 1);
      bus.lsu_funct3  = f3;
      bus.lsu_addr_lo = ofs;
      bus.lsu_rdata   = rd_v;
      tick();
      bus.lsu_valid = 1'b0;
      exp_cnt++;
      vectors++; if (bus.we !== 1'b1 || bus.waddr !== 5'(i + 1)) begin miscompares++; $display("FAIL load%0d_port got we=%b waddr=%0d expected we=1 waddr=%0d", i, bus.we, bus.waddr, i + 1); end
      vectors++; if (bus.wdata !== exp_v) begin miscompares++; $display("FAIL load%0d_wdata got %h expected %h", i, bus.wdata, exp_v); end
      vectors++; if (bus.retire_cnt !== exp_cnt) begin miscompares++; $display("FAIL load%0d_cnt got %0d expected %0d", i, bus.retire_cnt, exp_cnt); end
    end
    tick();
  endtask

  task automatic test_x0_and_illegal();
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd0;
    bus.alu_data  = 64'hFF;
    tick();
    bus.alu_valid = 1'b0;
    tick();
    exp_cnt++;
    vectors++; if (bus.retire !== 1'b1) begin miscompares++; $display("FAIL x0_retire got %b expected 1", bus.retire); end
    vectors++; if (bus.we !== 1'b0) begin miscompares++; $display("FAIL x0_we got %b expected 0", bus.we); end
    vectors++; if (bus.waddr !== 5'd0 || bus.wdata !== 64'd0) begin miscompares++; $display("FAIL x0_port got waddr=%0d wdata=%h expected 0/0", bus.waddr, bus.wdata); end
    bus.lsu_valid   = 1'b1;
    bus.lsu_rd      = 5'd3;
    bus.lsu_funct3  = 3'd7;
    bus.lsu_addr_lo = 3'd0;
    bus.lsu_rdata   = 64'h1111_2222_3333_4444;
    tick();
    bus.lsu_valid = 1'b0;
    exp_cnt++;
    vectors++; if (bus.retire !== 1'b1) begin miscompares++; $display("FAIL f3_7_retire got %b expected 1", bus.retire); end
    vectors++; if (bus.we !== 1'b0) begin miscompares++; $display("FAIL f3_7_we got %b expected 0", bus.we); end
    vectors++; if (bus.wdata !== 64'd0) begin miscompares++; $display("FAIL f3_7_wdata got %h expected 0", bus.wdata); end
    vectors++; if (bus.retire_cnt !== exp_cnt) begin miscompares++; $display("FAIL f3_7_cnt got %0d expected %0d", bus.retire_cnt, exp_cnt); end
    tick();
  endtask

  task automatic test_back_to_back();
    int lidx;
    int aidx;
    logic       exp_rdy;
    logic [4:0] exp_rd;
    logic       lfire;
    logic       afire;
    lidx = 0;
    aidx = 0;
    for (int e = 1; e <= 7; e++) begin
      case (e)
        1: begin exp_rdy = 1'b1; exp_rd = 5'd10; end
        2: begin exp_rdy = 1'b1; exp_rd = 5'd11; end
        3: begin exp_rdy = 1'b0; exp_rd = 5'd20; end
        4: begin exp_rdy = 1'b1; exp_rd = 5'd12; end
        5: begin exp_rdy = 1'b0; exp_rd = 5'd21; end
        6: begin exp_rdy = 1'b1; exp_rd = 5'd13; end
        default: begin exp_rdy = 1'b1; exp_rd = 5'd22; end
      endcase
      bus.lsu_valid   = (lidx < 4);
      bus.lsu_rd      = 5'(10 + lidx);
      bus.lsu_funct3  = 3'd3;
      bus.lsu_addr_lo = 3'd0;
      bus.lsu_rdata   = 64'h1000 + 64'(lidx);
      bus.alu_valid   = (aidx < 3);
      bus.alu_rd      = 5'(20 + aidx);
      bus.alu_data    = 64'h2000 + 64'(aidx);
      #1;
      vectors++; if (bus.alu_ready !== exp_rdy || bus.lsu_ready !== exp_rdy) begin miscompares++; $display("FAIL b2b_ready edge%0d got alu=%b lsu=%b expected %b", e, bus.alu_ready, bus.lsu_ready, exp_rdy); end
      lfire = bus.lsu_valid && bus.lsu_ready;
      afire = bus.alu_valid && bus.alu_ready;
      tick();
      if (lfire) lidx++;
      if (afire) aidx++;
      exp_cnt++;
      vectors++; if (bus.we !== 1'b1 || bus.waddr !== exp_rd) begin miscompares++; $display("FAIL b2b_port edge%0d got we=%b waddr=%0d expected we=1 waddr=%0d", e, bus.we, bus.waddr, exp_rd); end
      vectors++; if (bus.wdata !== ((exp_rd >= 5'd20) ? 64'h2000 + 64'(exp_rd - 5'd20) : 64'h1000 + 64'(exp_rd - 5'd10))) begin miscompares++; $display("FAIL b2b_wdata edge%0d got %h for rd %0d", e, bus.wdata, exp_rd); end
    end
    idle_inputs();
    vectors++; if (bus.retire_cnt !== exp_cnt) begin miscompares++; $display("FAIL b2b_cnt got %0d expected %0d", bus.retire_cnt, exp_cnt); end
    tick();
    vectors++; if (bus.we !== 1'b0 || bus.retire !== 1'b0) begin miscompares++; $display("FAIL b2b_drained got we=%b retire=%b expected 0/0", bus.we, bus.retire); end
    vectors++; if (bus.alu_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_empty_ready got %b expected 1", bus.alu_ready); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 2; k++) begin
      bus.lsu_valid   = 1'b1;
      bus.lsu_rd      = 5'(6 + k);
      bus.lsu_funct3  = 3'd3;
      bus.lsu_rdata   = 64'h77;
      bus.alu_valid   = 1'b1;
      bus.alu_rd      = 5'(8 + k);
      bus.alu_data    = 64'h88;
      tick();
    end
    idle_inputs();
    vectors++; if (bus.alu_ready !== 1'b0) begin miscompares++; $display("FAIL mid_full_ready got %b expected 0", bus.alu_ready); end
    rst = 1'b1;
    tick();
    vectors++; if (bus.we !== 1'b0 || bus.retire_cnt !== 64'd0) begin miscompares++; $display("FAIL mid_rst got we=%b cnt=%0d expected 0/0", bus.we, bus.retire_cnt); end
    rst = 1'b0;
    #1;
    vectors++; if (bus.alu_ready !== 1'b1 || bus.lsu_ready !== 1'b1) begin miscompares++; $display("FAIL mid_ready got alu=%b lsu=%b expected 1/1", bus.alu_ready, bus.lsu_ready); end
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++; if (bus.we !== 1'b0 || bus.retire !== 1'b0 || bus.retire_cnt !== 64'd0) begin miscompares++; $display("FAIL mid_after%0d got we=%b retire=%b cnt=%0d expected 0/0/0", k, bus.we, bus.retire, bus.retire_cnt); end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_cnt     = 64'd0;
    rst         = 1'b1;
    idle_inputs();
    test_reset();
    test_alu();
    test_load_ext();
    test_x0_and_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
